// File: rtl/button_conditioner_if.sv
// Button bundle between the raw push-button pins and the game logic.
// master drives the raw buttons; slave (the conditioner) returns command pulses and debounced levels.
interface button_conditioner_if;
  logic       btn_left_raw;
  logic       btn_right_raw;
  logic       btn_drop_raw;
  logic       move_left;
  logic       move_right;
  logic       drop_piece;
  logic [2:0] btn_state;

  modport master (
    output btn_left_raw, btn_right_raw, btn_drop_raw,
    input  move_left, move_right, drop_piece, btn_state
  );

  modport slave (
    input  btn_left_raw, btn_right_raw, btn_drop_raw,
    output move_left, move_right, drop_piece, btn_state
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises, debounces and converts three push-buttons into single-cycle game commands.
// Optional left/right auto-repeat is compiled in when AUTO_REPEAT_EN is defined.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 3750000
) (
  input  logic                 clk_25MHz,
  input  logic                 rst_n,
  button_conditioner_if.slave  bus
);

  localparam int             DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]      raw_s;
  logic [2:0]      sync1_r;
  logic [2:0]      sync2_r;
  logic [DB_W-1:0] db_cnt_r [3];
  logic [2:0]      level_r;
  logic [2:0]      level_d_r;
  logic [2:0]      rise_s;
  logic [1:0]      fire_s;
  logic            excl_s;
  logic            move_left_r;
  logic            move_right_r;
  logic            drop_piece_r;

  // Bit order {drop, right, left} matches btn_state.
  assign raw_s  = {bus.btn_drop_raw, bus.btn_right_raw, bus.btn_left_raw};
  assign rise_s = level_r & ~level_d_r;

  // Two-flop synchroniser for the asynchronous button pins
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Per-button debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        db_cnt_r[i] <= '0;
      end
      level_r   <= 3'b000;
      level_d_r <= 3'b000;
    end else begin
      level_d_r <= level_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] == level_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (db_cnt_r[i] == DB_LAST) begin
          db_cnt_r[i] <= '0;
          level_r[i]  <= ~level_r[i];
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int              RP_MAX     = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int              RP_W       = $clog2(RP_MAX);
  localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HOLD_DELAY  = 2'd1,
    HOLD_REPEAT = 2'd2
  } rep_state_e;

  rep_state_e      rep_state_r [2];
  rep_state_e      rep_cand_s  [2];
  rep_state_e      rep_state_nx[2];
  logic [RP_W-1:0] rep_cnt_r   [2];
  logic [RP_W-1:0] rep_cand_cnt_s[2];
  logic [RP_W-1:0] rep_cnt_nx  [2];

  // Repeat FSM state and counter registers (index 0 = left, 1 = right)
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 2; j++) begin
        rep_state_r[j] <= IDLE;
        rep_cnt_r[j]   <= '0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        rep_state_r[j] <= rep_state_nx[j];
        rep_cnt_r[j]   <= rep_cnt_nx[j];
      end
    end
  end

  // Repeat next-state logic; a release always wins over a pending repeat pulse
  always_comb begin
    fire_s = 2'b00;
    for (int j = 0; j < 2; j++) begin
      rep_cand_s[j]     = rep_state_r[j];
      rep_cand_cnt_s[j] = rep_cnt_r[j] + RP_W'(1);
      if (!level_r[j]) begin
        rep_cand_s[j]     = IDLE;
        rep_cand_cnt_s[j] = '0;
      end else begin
        case (rep_state_r[j])
          IDLE: begin
            rep_cand_cnt_s[j] = '0;
            if (rise_s[j]) begin
              rep_cand_s[j] = HOLD_DELAY;
              fire_s[j]     = 1'b1;
            end else begin
              rep_cand_s[j] = IDLE;
            end
          end
          HOLD_DELAY: begin
            if (rep_cnt_r[j] == DELAY_LAST) begin
              rep_cand_s[j]     = HOLD_REPEAT;
              rep_cand_cnt_s[j] = '0;
              fire_s[j]         = 1'b1;
            end else begin
              rep_cand_s[j] = HOLD_DELAY;
            end
          end
          HOLD_REPEAT: begin
            if (rep_cnt_r[j] == RATE_LAST) begin
              rep_cand_cnt_s[j] = '0;
              fire_s[j]         = 1'b1;
            end else begin
              rep_cand_cnt_s[j] = rep_cnt_r[j] + RP_W'(1);
            end
          end
          default: begin
            rep_cand_s[j]     = IDLE;
            rep_cand_cnt_s[j] = '0;
          end
        endcase
      end
    end
    // Opposing commands cancel; both machines restart their initial delay.
    excl_s = fire_s[0] & fire_s[1];
    for (int j = 0; j < 2; j++) begin
      rep_state_nx[j] = excl_s ? HOLD_DELAY : rep_cand_s[j];
      rep_cnt_nx[j]   = excl_s ? '0 : rep_cand_cnt_s[j];
    end
  end
`else
  // One pulse per press, same as drop
  always_comb begin
    fire_s = rise_s[1:0];
    excl_s = fire_s[0] & fire_s[1];
  end
`endif

  // Registered command pulses
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      move_left_r  <= 1'b0;
      move_right_r <= 1'b0;
      drop_piece_r <= 1'b0;
    end else begin
      move_left_r  <= fire_s[0] & ~excl_s;
      move_right_r <= fire_s[1] & ~excl_s;
      drop_piece_r <= rise_s[2];
    end
  end

  assign bus.move_left  = move_left_r;
  assign bus.move_right = move_right_r;
  assign bus.drop_piece = drop_piece_r;
  assign bus.btn_state  = level_r;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (DEBOUNCE 4, DELAY 20, RATE 8).
// Expectations follow whichever AUTO_REPEAT_EN setting the design is built with.
module tb_button_conditioner;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_RATE     (8)
  ) dut (
    .clk_25MHz (clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Compares {btn_state, drop, right, left}
  task automatic chk(input string tag, input logic [2:0] exp_pulse, input logic [2:0] exp_state);
    logic [5:0] obs;
    logic [5:0] exp;
    obs = {bus.btn_state, bus.drop_piece, bus.move_right, bus.move_left};
    exp = {exp_state, exp_pulse};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag, input logic [2:0] exp_pulse, input logic [2:0] exp_state);
    @(posedge clk);
    @(negedge clk);
    chk(tag, exp_pulse, exp_state);
  endtask

  function automatic bit is_repeat_edge(input int k);
`ifdef AUTO_REPEAT_EN
    return (k == 7) || (k == 27) || (k == 35) || (k == 43) || (k == 51) || (k == 59);
`else
    return (k == 7);
`endif
  endfunction

  initial begin
    clk               = 1'b0;
    rst_n             = 1'b0;
    checks            = 0;
    failures          = 0;
    bus.btn_left_raw  = 1'b0;
    bus.btn_right_raw = 1'b0;
    bus.btn_drop_raw  = 1'b0;

    #23;
    chk("reset_state", 3'b000, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) tick("idle", 3'b000, 3'b000);

    // Clean drop press held 40 cycles
    bus.btn_drop_raw = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      tick("drop_press", (k == 7) ? 3'b100 : 3'b000, (k >= 6 && k < 46) ? 3'b100 : 3'b000);
      if (k == 40) bus.btn_drop_raw = 1'b0;
    end

    // Bounce on left: high 3, low 1, high 2, then low
    bus.btn_left_raw = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick("left_bounce", 3'b000, 3'b000);
      bus.btn_left_raw = (k + 1 <= 3) || (k + 1 == 5) || (k + 1 == 6);
    end

    // Right held 60 cycles: auto-repeat (or single pulse)
    bus.btn_right_raw = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      tick("right_hold", is_repeat_edge(k) ? 3'b010 : 3'b000, (k >= 6 && k < 66) ? 3'b010 : 3'b000);
      if (k == 60) bus.btn_right_raw = 1'b0;
    end

    // Simultaneous left and right for 10 cycles
    bus.btn_left_raw  = 1'b1;
    bus.btn_right_raw = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick("simultaneous", 3'b000, (k >= 6 && k < 16) ? 3'b011 : 3'b000);
      if (k == 10) begin
        bus.btn_left_raw  = 1'b0;
        bus.btn_right_raw = 1'b0;
      end
    end

    // Left held, reset for 3 cycles at cycle 15, held through release
    bus.btn_left_raw = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick("pre_reset_hold", (k == 7) ? 3'b001 : 3'b000, (k >= 6) ? 3'b001 : 3'b000);
    end
    rst_n = 1'b0;
    #1;
    chk("async_reset", 3'b000, 3'b000);
    for (int k = 1; k <= 3; k++) tick("in_reset", 3'b000, 3'b000);
    rst_n = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      tick("post_reset_hold", (k == 7) ? 3'b001 : 3'b000, (k >= 6 && k < 26) ? 3'b001 : 3'b000);
      if (k == 20) bus.btn_left_raw = 1'b0;
    end

    // Fresh right press after everything settles gives a pulse again
    bus.btn_right_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick("right_again", (k == 7) ? 3'b010 : 3'b000, (k >= 6) ? 3'b010 : 3'b000);
    end
    bus.btn_right_raw = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000: consecutive stable cycles needed to accept a level change (10 ms at 25 MHz); legal range >= 2.
REQ-002 Parameter REPEAT_DELAY, default 12500000: cycles a left/right press is held before the first auto-repeat pulse; legal range >= 2.
REQ-003 Parameter REPEAT_RATE, default 3750000: cycles between subsequent auto-repeat pulses; legal range >= 2.
REQ-004 clk_25MHz  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 btn_left_raw  input  1  asynchronous, bouncy, active-high left button.
REQ-007 btn_right_raw  input  1  asynchronous, bouncy, active-high right button.
REQ-008 btn_drop_raw  input  1  asynchronous, bouncy, active-high drop button.
REQ-009 move_left  output  1  registered single-cycle command pulse; drives the game's move_left.
REQ-010 move_right  output  1  registered single-cycle command pulse; drives the game's move_right.
REQ-011 drop_piece  output  1  registered single-cycle command pulse; drives the game's drop_piece.
REQ-012 btn_state  output  3  debounced levels {drop, right, left}, registered.

Function
REQ-013 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each button SHALL have an independent debounce counter, $clog2(DEBOUNCE_CYCLES) bits wide:
  - increments while the synchronized value differs from the debounced level;
  - clears to 0 in any cycle the values match.
REQ-015 The debounced level SHALL toggle, and its counter SHALL clear, on the edge where the counter equals DEBOUNCE_CYCLES-1 and the values still differ.
REQ-016 A raw change held stable SHALL change btn_state exactly DEBOUNCE_CYCLES+2 rising edges after the first sampling edge.
REQ-017 A debounced rising level SHALL assert the matching pulse output exactly one cycle later, for exactly one cycle.
REQ-018 Debounced falling levels SHALL produce no pulse.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no btn_state change and no pulse.
REQ-020 Left/right mutual exclusion: if move_left and move_right would assert in the same cycle, neither SHALL assert.
  - Both repeat machines SHALL return to HOLD_DELAY with their counters cleared.
REQ-021 drop_piece SHALL be independent of left/right and SHALL never auto-repeat; one press gives one pulse.
REQ-022 Left and right each SHALL have a 3-state repeat FSM, IDLE / HOLD_DELAY / HOLD_REPEAT, with a $clog2(max(REPEAT_DELAY,REPEAT_RATE))-bit counter.
  - IDLE -> HOLD_DELAY on the debounced rise; emits the initial pulse; counter cleared.
  - HOLD_DELAY -> HOLD_REPEAT when the counter reaches REPEAT_DELAY-1; emits a pulse; counter cleared.
  - HOLD_REPEAT emits a pulse each time the counter reaches REPEAT_RATE-1, then clears the counter and stays.
  - Any state -> IDLE on the debounced fall; counter cleared; no pulse.
REQ-023 Outputs SHALL be glitch-free flop outputs, with no combinational path from any input to any output.

Reset
REQ-024 Asserting rst_n low SHALL immediately clear, regardless of clock:
  - all synchronizer flops, debounce counters and debounced levels;
  - repeat counters, with both FSMs to IDLE;
  - all outputs to 0.
REQ-025 A button held through reset release SHALL be treated as a new press: exactly one pulse at DEBOUNCE_CYCLES+3 edges after release, then auto-repeat per REQ-022.
REQ-026 Reset asserted mid-debounce or mid-repeat SHALL discard the partial count, and no pulse SHALL be emitted during reset.

Configuration
REQ-027 Macro AUTO_REPEAT_EN:
  - defined: the REQ-022 repeat FSMs and counters are compiled in;
  - undefined: they are omitted, and left/right behave like drop, one pulse per press.
  - REQ-020 mutual exclusion SHALL apply in both builds.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, AUTO_REPEAT_EN defined)
REQ-028 Clean press: btn_drop_raw rises and holds for 40 cycles -> btn_state[2] rises at edge 6, drop_piece high only at edge 7, no further pulses.
REQ-029 Bounce: btn_left_raw toggles high 3 cycles, low 1, high 2, low -> no move_left pulse; btn_state stays 0.
REQ-030 Auto-repeat: btn_right_raw held 60 cycles -> move_right pulses at edges 7, 27, 35, 43, 51, 59; release -> no more pulses; FSM back in IDLE.
REQ-031 Simultaneous press: btn_left_raw and btn_right_raw rise in the same cycle, both held for 10 cycles -> neither move_left nor move_right ever pulses.
REQ-032 Reset mid-hold: rst_n low for 3 cycles at cycle 15 of a held left press -> all outputs 0 within the reset cycle; after release, move_left pulses exactly DEBOUNCE_CYCLES+3=7 edges later.
REQ-033 AUTO_REPEAT_EN undefined: right held 60 cycles -> exactly one move_right pulse at edge 7.
